// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// Provides the responder FSM state encoding and default array geometry.
package typedefs;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_READ  = 2'd1,
        M_WRITE = 2'd2,
        M_ERR   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Storage array: one synchronous write port, one combinational read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Contents not reset.
module mem_array
    import typedefs::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU strobes with a loader side port.
// Ports: clk/rst_, CPU mem_rd/mem_wr/addr/data_in -> data_out/data_oe,
//        loader ld_valid/ld_addr/ld_data -> ld_ready, prot_err, rd_cnt, wr_cnt.
module mem_responder
    import typedefs::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_oe,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  prot_err,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    mem_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_data_oe;
    logic                  r_prot_err;
    logic [CNT_WIDTH-1:0]  r_rd_cnt;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;

    logic                  w_idle;
    logic                  w_cpu_we;
    logic                  w_ld_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_idle   = (r_state == M_IDLE);
    assign ld_ready = w_idle & ~mem_rd & ~mem_wr;

    // CPU write only on the IDLE->WRITE edge; loader only on a quiet bus.
    assign w_cpu_we = w_idle & mem_wr & ~mem_rd;
    assign w_ld_we  = ld_valid & ld_ready;

    // Gate with rst_ so no write lands on an edge while reset is held.
    assign w_we    = rst_ & (w_cpu_we | w_ld_we);
    assign w_waddr = w_cpu_we ? addr : ld_addr;
    assign w_wdata = w_cpu_we ? data_in : ld_data;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (addr),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= M_IDLE;
            r_data_q   <= '0;
            r_data_oe  <= 1'b0;
            r_prot_err <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            unique case (r_state)
                M_IDLE: begin
                    if (mem_rd && mem_wr) begin
                        r_prot_err <= 1'b1;
                        r_state    <= M_ERR;
                    end else if (mem_rd) begin
                        r_data_q  <= w_rd_data;
                        r_data_oe <= 1'b1;
                        if (r_rd_cnt != CNT_MAX) begin
                            r_rd_cnt <= r_rd_cnt + CNT_ONE;
                        end
                        r_state <= M_READ;
                    end else if (mem_wr) begin
                        if (r_wr_cnt != CNT_MAX) begin
                            r_wr_cnt <= r_wr_cnt + CNT_ONE;
                        end
                        r_state <= M_WRITE;
                    end
                end
                M_READ: begin
                    if (mem_wr) begin
                        r_prot_err <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_state    <= M_ERR;
                    end else if (!mem_rd) begin
                        // data_q keeps the last word; only the enable drops.
                        r_data_oe <= 1'b0;
                        r_state   <= M_IDLE;
                    end else begin
                        r_data_q <= w_rd_data;
                    end
                end
                M_WRITE: begin
                    if (mem_rd) begin
                        r_prot_err <= 1'b1;
                        r_state    <= M_ERR;
                    end else if (!mem_wr) begin
                        r_state <= M_IDLE;
                    end
                end
                M_ERR: begin
                    if (!mem_rd && !mem_wr) begin
                        r_state <= M_IDLE;
                    end
                end
                default: r_state <= M_IDLE;
            endcase
        end
    end

    assign data_out = r_data_q;
    assign data_oe  = r_data_oe;
    assign prot_err = r_prot_err;
    assign rd_cnt   = r_rd_cnt;
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Table-driven per-cycle vectors plus hand-written reset and saturation runs.
module tb_mem_responder;

    logic       clk;
    logic       rst_;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       ld_valid;
    logic       ld_ready;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;
    logic       prot_err;
    logic [3:0] rd_cnt;
    logic [3:0] wr_cnt;

    int n_cmp;
    int n_bad;

    mem_responder #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (8),
        .CNT_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .prot_err (prot_err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [4:0] a;
        logic [7:0] din;
        logic       lv;
        logic [4:0] la;
        logic [7:0] ld;
        logic       rdy;
        logic [7:0] dout;
        logic       oe;
        logic       perr;
        logic [3:0] rdc;
        logic [3:0] wrc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [4:0] a,
        input logic [7:0] din, input logic lv, input logic [4:0] la,
        input logic [7:0] ld, input logic rdy, input logic [7:0] dout,
        input logic oe, input logic perr, input logic [3:0] rdc,
        input logic [3:0] wrc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.din = din;
        v.lv = lv; v.la = la; v.ld = ld; v.rdy = rdy;
        v.dout = dout; v.oe = oe; v.perr = perr;
        v.rdc = rdc; v.wrc = wrc;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [4:0] a,
                         input logic [7:0] din, input logic lv,
                         input logic [4:0] la, input logic [7:0] ld);
        mem_rd = rd; mem_wr = wr; addr = a; data_in = din;
        ld_valid = lv; ld_addr = la; ld_data = ld;
    endtask

    task automatic chk_outs(input int row, input logic [7:0] dout,
                            input logic oe, input logic perr,
                            input logic [3:0] rdc, input logic [3:0] wrc);
        chk("data_out", row, 32'(data_out), 32'(dout));
        chk("data_oe", row, 32'(data_oe), 32'(oe));
        chk("prot_err", row, 32'(prot_err), 32'(perr));
        chk("rd_cnt", row, 32'(rd_cnt), 32'(rdc));
        chk("wr_cnt", row, 32'(wr_cnt), 32'(wrc));
    endtask

    // Drive at negedge, check ready before the edge, outputs after it.
    task automatic cyc(input int row, input vec_t v);
        @(negedge clk);
        drive(v.rd, v.wr, v.a, v.din, v.lv, v.la, v.ld);
        #1;
        chk("ld_ready", row, 32'(ld_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk_outs(row, v.dout, v.oe, v.perr, v.rdc, v.wrc);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_ = 1'b0;
        drive(0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);

        //          rd wr a      din    lv la     ld     rdy dout  oe pe rc wc
        tbl.push_back(mk(0, 0, 5'd0, 8'h00, 1, 5'd3, 8'hA5, 1, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 8'h00, 1, 5'd2, 8'h3C, 1, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'd0, 8'h00, 1, 5'd9, 8'h99, 1, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5'd7, 8'h11, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 5'd7, 8'h22, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 5'd7, 8'h33, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 0, 8'h11, 1, 0, 2, 1));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 0, 2, 1));
        tbl.push_back(mk(0, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 0, 2, 1));
        tbl.push_back(mk(1, 0, 5'd7, 8'h00, 1, 5'd2, 8'hFF, 0, 8'h11, 1, 0, 3, 1));
        tbl.push_back(mk(1, 0, 5'd2, 8'h00, 1, 5'd2, 8'hFF, 0, 8'h3C, 1, 0, 3, 1));
        tbl.push_back(mk(0, 0, 5'd2, 8'h00, 1, 5'd2, 8'hFF, 0, 8'h3C, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 5'd2, 8'h00, 1, 5'd2, 8'hFF, 1, 8'h3C, 0, 0, 3, 1));
        tbl.push_back(mk(1, 0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 0, 8'hFF, 1, 0, 4, 1));
        tbl.push_back(mk(0, 0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 0, 8'hFF, 0, 0, 4, 1));
        tbl.push_back(mk(1, 1, 5'd9, 8'h77, 0, 5'd0, 8'h00, 0, 8'hFF, 0, 1, 4, 1));
        tbl.push_back(mk(1, 0, 5'd9, 8'h00, 0, 5'd0, 8'h00, 0, 8'hFF, 0, 1, 4, 1));
        tbl.push_back(mk(0, 0, 5'd9, 8'h00, 0, 5'd0, 8'h00, 0, 8'hFF, 0, 1, 4, 1));
        tbl.push_back(mk(1, 0, 5'd9, 8'h00, 0, 5'd0, 8'h00, 0, 8'h99, 1, 1, 5, 1));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 1, 5, 1));
        tbl.push_back(mk(1, 1, 5'd3, 8'h55, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 5, 1));
        tbl.push_back(mk(0, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 5, 1));
        tbl.push_back(mk(0, 1, 5'd4, 8'h44, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 5, 2));
        tbl.push_back(mk(1, 1, 5'd4, 8'h66, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 5, 2));
        tbl.push_back(mk(0, 0, 5'd4, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 5, 2));
        tbl.push_back(mk(1, 0, 5'd4, 8'h00, 0, 5'd0, 8'h00, 0, 8'h44, 1, 1, 6, 2));
        tbl.push_back(mk(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 1, 1, 6, 2));
        tbl.push_back(mk(0, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00, 0, 8'hA5, 0, 1, 6, 2));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_outs(-1, 8'h00, 0, 0, 4'd0, 4'd0);
        chk("ld_ready_rst", -1, 32'(ld_ready), 32'd1);
        @(negedge clk);
        rst_ = 1'b1;

        foreach (tbl[i]) cyc(i, tbl[i]);

        // Reset asserted while in M_READ aborts immediately.
        @(negedge clk);
        drive(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_read_oe", 100, 32'(data_oe), 32'd1);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk_outs(101, 8'h00, 0, 0, 4'd0, 4'd0);
        drive(0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
        @(negedge clk);
        rst_ = 1'b1;

        // Preload mem[5], then hold reset across a write-strobe edge.
        @(negedge clk);
        drive(0, 0, 5'd0, 8'h00, 1, 5'd5, 8'h5E);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
        rst_ = 1'b0;
        drive(0, 1, 5'd5, 8'hEE, 0, 5'd0, 8'h00);
        @(posedge clk);
        #1;
        chk_outs(102, 8'h00, 0, 0, 4'd0, 4'd0);
        @(negedge clk);
        drive(0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
        rst_ = 1'b1;
        @(negedge clk);
        drive(1, 0, 5'd5, 8'h00, 0, 5'd0, 8'h00);
        @(posedge clk);
        #1;
        chk_outs(103, 8'h5E, 1, 0, 4'd1, 4'd0);
        @(negedge clk);
        drive(0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);

        // Read counter saturates at 4'hF.
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00);
            @(negedge clk);
            drive(0, 0, 5'd3, 8'h00, 0, 5'd0, 8'h00);
            if (k == 14) begin
                chk("rd_cnt_15", 104, 32'(rd_cnt), 32'hF);
            end
        end
        @(negedge clk);
        chk("rd_cnt_sat", 105, 32'(rd_cnt), 32'hF);
        chk("wr_cnt_sat", 105, 32'(wr_cnt), 32'h0);
        chk("data_sat", 105, 32'(data_out), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
